// File: rtl/conv_cfg_pkg.sv
// Shared configuration for the convolution datapath: sequencer states,
// default geometry and small elaboration-time helpers.
package conv_cfg_pkg;

   localparam int IMAGE_SIZE_DEF  = 36;
   localparam int KERNEL_SIZE_DEF = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_NEXT,
      S_DONE
   } seq_state_t;

   // Bits needed to index v distinct values; never less than 1 so ports stay legal.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

   function automatic int out_size_f(input int img, input int k);
      return img - k + 1;
   endfunction

endpackage

// File: rtl/conv_layer_sequencer_raster.sv
// Raster (row, column) position tracker for a pixel stream, with a flag
// that marks when the current pixel completes a kernel-sized window.
module raster_pos_counter
   import conv_cfg_pkg::*;
#(
   parameter int image_size  = IMAGE_SIZE_DEF,
   parameter int kernel_size = KERNEL_SIZE_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_adv,
   output logic o_win_ok
);

   localparam int RCW = clog2_min1(image_size + 1);
   localparam logic [RCW-1:0] C_LAST = RCW'(image_size - 1);
   localparam logic [RCW-1:0] K_LAST = RCW'(kernel_size - 1);

   logic [RCW-1:0] r_row;
   logic [RCW-1:0] r_col;

   // Advance column per pixel, wrapping into the next row at the image edge.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_adv) begin
         if (r_col == C_LAST) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_win_ok = i_adv && (r_row >= K_LAST) && (r_col >= K_LAST);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer-level control for the line buffer + convolution datapath: streams the
// feature map, gates complete windows, steps weight sets and addresses results.
module conv_layer_sequencer
   import conv_cfg_pkg::*;
#(
   parameter int image_size  = IMAGE_SIZE_DEF,
   parameter int kernel_size = KERNEL_SIZE_DEF,
   parameter int num_out_ch  = 4,
   parameter int feat_aw     = 11,
   parameter int out_aw      = 12,
   localparam int WS_W       = clog2_min1(num_out_ch)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   output logic              feat_rd_en,
   output logic [feat_aw-1:0] feat_addr,
   output logic              pix_valid,
   output logic              win_valid,
   output logic              lb_clr,
   output logic [WS_W-1:0]   weight_sel,
   input  logic              conv_valid,
   output logic              out_wr_en,
   output logic [out_aw-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int OUT_SIZE = out_size_f(image_size, kernel_size);
   localparam int OUT_PIX  = OUT_SIZE * OUT_SIZE;
   localparam int QW       = clog2_min1(OUT_PIX + 1);
   localparam logic [feat_aw-1:0] P_LAST    = feat_aw'(image_size * image_size - 1);
   localparam logic [QW-1:0]      Q_FULL    = QW'(OUT_PIX);
   localparam logic [WS_W-1:0]    WS_LAST   = WS_W'(num_out_ch - 1);
   localparam logic [out_aw-1:0]  OUT_PIX_A = out_aw'(OUT_PIX);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [feat_aw-1:0] r_p;
   logic [QW-1:0]     r_q;
   logic [WS_W-1:0]   r_wsel;
   logic              r_err;
   logic              r_pix_valid;
   logic              r_win_valid;
   logic              w_rd;
   logic              w_clr;
   logic              w_accept;
   logic              w_conv_ok;
   logic              w_overflow;
   logic              w_win_ok;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode plus the read and clear strobes that depend only on state.
   always_comb begin
      w_state_nxt = r_state;
      w_rd        = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_CLEAR;
         S_CLEAR: begin
            w_clr       = 1'b1;
            w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (!stall) begin
               w_rd = 1'b1;
               if (r_p == P_LAST) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_q == Q_FULL) w_state_nxt = (r_wsel < WS_LAST) ? S_NEXT : S_DONE;
         end
         S_NEXT:   w_state_nxt = S_CLEAR;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_conv_ok  = conv_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                       (r_q != Q_FULL);
   assign w_overflow = conv_valid && !w_conv_ok;

   // Pixel/result counters, weight-set index and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p    <= '0;
         r_q    <= '0;
         r_wsel <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept)               r_wsel <= '0;
         else if (r_state == S_NEXT) r_wsel <= r_wsel + 1'b1;
         if (w_clr) begin
            r_p <= '0;
            r_q <= '0;
         end else begin
            if (w_rd)      r_p <= r_p + 1'b1;
            if (w_conv_ok) r_q <= r_q + 1'b1;
         end
         if (w_overflow)    r_err <= 1'b1;
         else if (w_accept) r_err <= 1'b0;
      end
   end

   // RAM read latency alignment and one-cycle window flag after the completing pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_valid <= 1'b0;
         r_win_valid <= 1'b0;
      end else begin
         r_pix_valid <= w_rd;
         r_win_valid <= w_win_ok;
      end
   end

   raster_pos_counter #(
      .image_size  (image_size),
      .kernel_size (kernel_size)
   ) u_raster (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_clr    (w_clr),
      .i_adv    (r_pix_valid),
      .o_win_ok (w_win_ok)
   );

   assign feat_rd_en = w_rd;
   assign feat_addr  = r_p;
   assign pix_valid  = r_pix_valid;
   assign win_valid  = r_win_valid;
   assign lb_clr     = w_clr;
   assign weight_sel = r_wsel;
   assign out_wr_en  = w_conv_ok;
   assign out_addr   = w_conv_ok ? (out_aw'(r_wsel) * OUT_PIX_A + out_aw'(r_q)) : '0;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign err        = r_err;

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Control block that runs one full convolution layer on the `line_buffer_5x5` → `traditional_conv` datapath.
- Streams the padded input feature map out of a synchronous feature RAM into the line buffer.
- Flags which line-buffer windows are complete, so the conv engine computes only on valid windows.
- Selects the weight set for each output channel and clears the line buffer between channel passes.
- Addresses the output RAM from the conv engine's result strobe, and reports busy/done/error to the layer controller above it.

## Interface
Parameters:
- `image_size`, 36, padded input edge length (pixels per row and rows per image)
- `kernel_size`, 5, window edge; output edge is `out_size = image_size - kernel_size + 1` (32)
- `num_out_ch`, 4, output channels (weight sets) processed per layer
- `feat_aw`, 11, feature RAM address width (≥ clog2(image_size²))
- `out_aw`, 12, output RAM address width (≥ clog2(num_out_ch·out_size²))

Ports (all synchronous to `clk`; all outputs reset to 0):
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to run a layer; accepted only in IDLE
- `stall`  in  1  while high, no new feature read is issued
- `feat_rd_en`  out  1  feature RAM read strobe
- `feat_addr`  out  feat_aw  feature RAM read address
- `pix_valid`  out  1  drives line buffer `in_valid`
- `win_valid`  out  1  drives conv `in_valid`; the current window is complete
- `lb_clr`  out  1  one-cycle clear of line buffer and conv pipeline
- `weight_sel`  out  clog2(num_out_ch)  index of the active weight set
- `conv_valid`  in  1  conv `out_valid`, one result per pulse
- `out_wr_en`  out  1  output RAM write strobe
- `out_addr`  out  out_aw  output RAM write address
- `busy`  out  1  high from the cycle after `start` is accepted until the DONE cycle inclusive
- `done`  out  1  one-cycle pulse at the end of the layer
- `err`  out  1  sticky overflow flag; cleared by `rst` or by the next accepted `start`

## Operation
State machine: IDLE, CLEAR, STREAM, DRAIN, NEXT, DONE.
- **IDLE**
  - `start` → CLEAR; sets `weight_sel`=0 and clears `err`.
  - `start` in any other state is ignored.
- **CLEAR**
  - `lb_clr`=1 for exactly one cycle.
  - Pixel counter p=0 and the per-channel result counter q=0.
  - → STREAM.
- **STREAM**
  - Each cycle with `stall`=0: `feat_rd_en`=1, `feat_addr`=p, p++.
  - When p reaches image_size²−1 and that read is issued → DRAIN.
  - `stall`=1: `feat_rd_en`=0 and p holds.
- **Pixel accounting**
  - `pix_valid` is `feat_rd_en` delayed by 1 (RAM read latency 1).
  - Row/column counters (r,c) advance on each `pix_valid`; c wraps at image_size−1 and increments r.
  - `win_valid` is asserted the cycle after a `pix_valid` whose (r,c) has r ≥ kernel_size−1 and c ≥ kernel_size−1.
  - Exactly out_size² windows per pass; the first is at p = (kernel_size−1)·image_size + kernel_size−1 = 148.
- **Results**
  - Each `conv_valid` in STREAM/DRAIN: `out_wr_en`=1 in the same cycle, `out_addr` = `weight_sel`·out_size² + q, then q++.
- **DRAIN**
  - Waits until q = out_size².
  - Then → NEXT if `weight_sel` < num_out_ch−1, else → DONE.
- **NEXT**
  - `weight_sel`++ → CLEAR.
- **DONE**
  - `done`=1 for one cycle → IDLE.
- **Overflow**
  - `conv_valid` while q = out_size², or in IDLE/CLEAR/NEXT/DONE, sets `err`=1.
  - No write is issued and q does not change.

## Timing
- `start` at cycle 0 → CLEAR at 1 (`lb_clr`=1) → first `feat_rd_en` at 2 → first `pix_valid` at 3 → first `win_valid` at 3+148+1 = 152 (no stalls).
- With no stalls, the last `feat_rd_en` is at cycle 2+image_size²−1 = 1297.
- `weight_sel` is stable from CLEAR through DRAIN of each pass.
- `out_addr` and `out_wr_en` are combinational from `conv_valid` and registered q, giving zero-cycle write latency.
- `stall` affects reads only. Pixels already read still produce `pix_valid`/`win_valid` on schedule.
- `rst` mid-layer, in any state: next cycle in IDLE with every output 0 and all counters 0.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Shared package `conv_cfg_pkg` holds:
  - state enum
  - `out_size` computation
  - clog2 helper
  - default `image_size`/`kernel_size`, shared with `line_buffer_5x5` and `traditional_conv`
- One natural sub-module, `raster_pos_counter`: (r,c) counters with wrap and a window-complete compare. Reused by future pooling control.
- The FSM, pixel/result counters and error flag live in the top module.

## Test plan
- **Basic layer**
  - Stimulus: reset; `start` at cycle 0, `stall`=0; behavioural RAM plus the real line buffer and conv.
  - Required: 4×1024 `out_wr_en` pulses with addresses 0..4095 in order; `done` exactly once; `err`=0.
- **Window gating**
  - Count `win_valid` per pass: 1024.
  - First `win_valid` at cycle 152; none while c<4 on any row.
- **Stall**
  - Stimulus: `stall`=1 for cycles 50–59 of pass 0.
  - Required: `feat_addr` frozen at 48; last read is 10 cycles later; output values identical to the basic run.
- **Overflow**
  - Force an extra `conv_valid` after q=1024 in DRAIN.
  - Required: `err`=1 sticky, no write, and the FSM still advances to NEXT.
- **Reset mid-run**
  - Stimulus: `rst` at cycle 700 of pass 1.
  - Required: next cycle all outputs 0; a fresh `start` completes normally with `weight_sel` starting at 0.
- **Ignored start**
  - `start` pulses during STREAM and DRAIN have no effect; `busy` stays 1; `done` appears once.
